// File: rtl/wptr_full.sv
// Write-side pointer and full logic for an asynchronous FIFO: binary/Gray write
// pointer, registered full/almost-full flags, fill level and sticky overflow.
module wptr_full #(
    parameter int ADDR_WIDTH   = 3,
    parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 2
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  wen,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wcount,
    output logic                  woverflow
);

    localparam logic [ADDR_WIDTH:0] THRESH    = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    // Inverting the two top Gray bits of the read pointer yields the pointer
    // value the writer reaches when exactly DEPTH entries are unread.
    localparam logic [ADDR_WIDTH:0] FULL_MASK = {2'b11, {(ADDR_WIDTH - 1){1'b0}}};

    logic [ADDR_WIDTH:0] wbin;
    logic [ADDR_WIDTH:0] wbin_next;
    logic [ADDR_WIDTH:0] wgray_next;
    logic [ADDR_WIDTH:0] rbin;
    logic [ADDR_WIDTH:0] wcount_next;
    logic                winc;
    logic                wfull_next;

    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ADDR_WIDTH; i++) begin
            rbin[i] = ^(wq2_rptr >> i);
        end
    end

    assign winc        = wen & ~wfull;
    assign wbin_next   = wbin + {{ADDR_WIDTH{1'b0}}, winc};
    assign wgray_next  = wbin_next ^ (wbin_next >> 1);
    assign wfull_next  = (wgray_next == (wq2_rptr ^ FULL_MASK));
    assign wcount_next = wbin_next - rbin;

    assign waddr = wbin[ADDR_WIDTH-1:0];

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wcount       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= wfull_next;
            walmost_full <= (wcount_next >= THRESH);
            wcount       <= wcount_next;
            woverflow    <= woverflow | (wen & wfull);
        end
    end

endmodule

// File: tb/tb_wptr_full.sv
// Directed bench for wptr_full (ADDR_WIDTH=3, AFULL_THRESH=6): fill, overflow,
// read release, simultaneous read/write at full, wrap and mid-stream reset.
module tb_wptr_full;

    localparam int AW = 3;

    logic          wclk = 1'b0;
    logic          wrst = 1'b1;
    logic          wen = 1'b0;
    logic [AW:0]   wq2_rptr = '0;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          wfull;
    logic          walmost_full;
    logic [AW:0]   wcount;
    logic          woverflow;

    int checks = 0;
    int errors = 0;

    always #5 wclk = ~wclk;

    wptr_full #(.ADDR_WIDTH(AW), .AFULL_THRESH(6)) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .wen          (wen),
        .wq2_rptr     (wq2_rptr),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wcount       (wcount),
        .woverflow    (woverflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_waddr"}, 32'(waddr), 0);
        check({tag, "_wptr"}, 32'(wptr), 0);
        check({tag, "_wfull"}, 32'(wfull), 0);
        check({tag, "_walmost_full"}, 32'(walmost_full), 0);
        check({tag, "_wcount"}, 32'(wcount), 0);
        check({tag, "_woverflow"}, 32'(woverflow), 0);
    endtask

    function automatic logic [AW:0] gray(input int b);
        logic [31:0] t;
        logic [AW:0] v;
        t = b;
        v = t[AW:0];
        return v ^ (v >> 1);
    endfunction

    initial begin
        int          wb;
        int          wraps;
        logic [AW:0] prev;

        #12;
        check_zero("por");
        step();
        wrst = 1'b0;

        // Fill to full with the reader idle.
        for (int i = 0; i < 8; i++) begin
            check("fill_waddr", 32'(waddr), 32'(i));
            wen = 1'b1;
            step();
            check("fill_wcount", 32'(wcount), 32'(i + 1));
            check("fill_afull", 32'(walmost_full), (i + 1 >= 6) ? 1 : 0);
            check("fill_wfull", 32'(wfull), (i + 1 == 8) ? 1 : 0);
        end
        check("full_wptr", 32'(wptr), 32'b1100);
        check("full_waddr", 32'(waddr), 0);
        check("full_ovf", 32'(woverflow), 0);

        // Writes against a full FIFO are dropped and flagged.
        repeat (3) step();
        check("ovf_wptr", 32'(wptr), 32'b1100);
        check("ovf_waddr", 32'(waddr), 0);
        check("ovf_flag", 32'(woverflow), 1);
        wen = 1'b0;
        step();
        check("ovf_sticky", 32'(woverflow), 1);
        check("ovf_wfull", 32'(wfull), 1);
        check("ovf_wcount", 32'(wcount), 8);

        // One read frees a slot; one write refills it.
        wq2_rptr = 4'b0001;
        step();
        check("rd_wfull", 32'(wfull), 0);
        check("rd_wcount", 32'(wcount), 7);
        wen = 1'b1;
        step();
        wen = 1'b0;
        check("refill_wfull", 32'(wfull), 1);
        check("refill_wptr", 32'(wptr), 32'b1101);
        check("refill_wcount", 32'(wcount), 8);

        // Read and write on the same edge while full: the write is still rejected.
        wq2_rptr = 4'b0011;
        wen = 1'b1;
        step();
        wen = 1'b0;
        check("simul_wptr", 32'(wptr), 32'b1101);
        check("simul_waddr", 32'(waddr), 1);
        check("simul_wfull", 32'(wfull), 0);
        check("simul_wcount", 32'(wcount), 7);

        // Reset between edges clears everything immediately.
        @(negedge wclk);
        wrst = 1'b1;
        #1;
        check_zero("rst_async");
        step();
        wrst = 1'b0;
        wq2_rptr = '0;

        // Wrap: reader trails the writer by two entries.
        wb = 0;
        wraps = 0;
        prev = wptr;
        for (int k = 0; k < 20; k++) begin
            wq2_rptr = gray((wb >= 2) ? wb - 2 : 0);
            wen = 1'b1;
            step();
            wb++;
            check("wrap_wfull", 32'(wfull), 0);
            check("wrap_onebit", 32'($countones(wptr ^ prev)), 1);
            check("wrap_waddr", 32'(waddr), 32'(wb % 8));
            if (waddr == 0) wraps++;
            prev = wptr;
        end
        wen = 1'b0;
        check("wrap_count", 32'(wraps), 2);
        check("wrap_wptr", 32'(wptr), 32'b0110);

        // Reset mid-stream after five writes.
        @(negedge wclk);
        wrst = 1'b1;
        #1;
        step();
        wrst = 1'b0;
        wq2_rptr = '0;
        wen = 1'b1;
        repeat (5) step();
        wen = 1'b0;
        check("mid_waddr_pre", 32'(waddr), 5);
        @(negedge wclk);
        wrst = 1'b1;
        #1;
        check_zero("rst_mid");
        step();
        wrst = 1'b0;
        check("post_waddr", 32'(waddr), 0);
        wen = 1'b1;
        step();
        wen = 1'b0;
        check("post_wptr", 32'(wptr), 32'b0001);
        check("post_waddr1", 32'(waddr), 1);
        check("post_wcount", 32'(wcount), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wptr_full.md
WPTR_FULL -- requirements
Module: wptr_full

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 3, meaning the FIFO address width; DEPTH = 2^ADDR_WIDTH.
REQ-002 SHALL provide parameter AFULL_THRESH, default DEPTH-2, meaning the fill level at or above which walmost_full asserts.
REQ-003 SHALL have port wclk  input  1  write-domain clock; all state is updated on its rising edge.
REQ-004 SHALL have port wrst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port wen  input  1  write request from the producer.
REQ-006 SHALL have port wq2_rptr  input  ADDR_WIDTH+1  read pointer, Gray-coded, already two-flop synchronized into wclk.
REQ-007 SHALL have port waddr  output  ADDR_WIDTH  write address to the dual-port memory.
REQ-008 SHALL have port wptr  output  ADDR_WIDTH+1  Gray-coded write pointer, sent to the read-domain synchronizer.
REQ-009 SHALL have port wfull  output  1  FIFO full flag; also drives the memory write gate.
REQ-010 SHALL have port walmost_full  output  1  fill level >= AFULL_THRESH.
REQ-011 SHALL have port wcount  output  ADDR_WIDTH+1  write-side fill level, range 0..DEPTH.
REQ-012 SHALL have port woverflow  output  1  sticky flag: a write was attempted while full.

Function
REQ-013 SHALL keep a binary pointer wbin, ADDR_WIDTH+1 bits; wbin_next = wbin + (wen & ~wfull), with modulo 2^(ADDR_WIDTH+1) wrap.
REQ-014 SHALL register wptr <= wbin_next ^ (wbin_next >> 1) on each wclk edge, so wptr is glitch-free and changes by at most one bit per cycle.
REQ-015 SHALL drive waddr = wbin[ADDR_WIDTH-1:0], taken directly from a register with no combinational path from inputs.
REQ-016 SHALL register wfull <= (wgray_next == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]}), where wgray_next is the Gray code of wbin_next.
REQ-017 SHALL assert wfull on the same edge that accepts the DEPTH-th unread write, so no extra write can slip through.
REQ-018 SHALL keep wfull deasserted only after a read pointer advance is visible on wq2_rptr; this pessimism is intended.
REQ-019 SHALL register wcount <= wbin_next - gray2bin(wq2_rptr), computed modulo 2^(ADDR_WIDTH+1).
REQ-020 SHALL register walmost_full <= (wcount_next >= AFULL_THRESH).
REQ-021 SHALL set woverflow when wen=1 and wfull=1 on an edge; woverflow stays set until reset.
REQ-022 SHALL ignore a write attempted while full: wbin, wptr and waddr do not change.
REQ-023 SHALL treat wen with a wq2_rptr change on the same edge by using the current wq2_rptr value; a full FIFO with a simultaneous read still rejects that write.
REQ-024 SHALL handle wrap-around transparently: waddr wraps DEPTH-1 -> 0, and the wbin MSB toggles.
REQ-025 SHALL contain no combinational path from wen or wq2_rptr to any output.

Reset
REQ-026 SHALL, while wrst=1 (asynchronous, immediate), force wbin=0, wptr=0, waddr=0, wfull=0, walmost_full=0, wcount=0 and woverflow=0.
REQ-027 SHALL, on reset asserted mid-operation, discard all pointer state; the read side is reset in the same system reset, so no pointer reconciliation is required.
REQ-028 SHALL accept the first write on the first wclk rising edge after wrst deasserts.

Verification (ADDR_WIDTH=3, AFULL_THRESH=6)
REQ-029 SHALL cover reset: assert wrst asynchronously between edges -> all outputs are 0 immediately, before the next edge.
REQ-030 SHALL cover fill to full: wq2_rptr=0000 with 8 consecutive wen cycles -> waddr runs 0..7 then 0; walmost_full=1 after the 6th write; wfull=1 after the 8th; wptr=1100; wcount=8.
REQ-031 SHALL cover overflow: with the FIFO full, drive wen=1 for 3 cycles -> wptr stays 1100, waddr stays 0, woverflow=1 and remains 1 after wen drops.
REQ-032 SHALL cover a read freeing space: from full, set wq2_rptr=0001 -> next edge gives wfull=0 and wcount=7; one further write gives wfull=1 and wptr=1101.
REQ-033 SHALL cover wrap: 20 writes interleaved with wq2_rptr tracking gray(wbin-2) -> wfull never asserts, waddr wraps twice, and wptr changes by exactly one bit per accepted write.
REQ-034 SHALL cover reset mid-stream: assert wrst after 5 writes -> all outputs 0; after release, the next write targets waddr=0.
